// File: rtl/svo_pkg.sv
// Shared types and constants for the SVO video pipeline stages.
package svo_pkg;

  // Bit positions inside the 4-bit output tuser.
  localparam int unsigned TUSER_HSYNC  = 0;
  localparam int unsigned TUSER_VSYNC  = 1;
  localparam int unsigned TUSER_BLANK  = 2;
  localparam int unsigned TUSER_FSTART = 3;
  localparam int unsigned TUSER_W      = 4;

  typedef enum logic [1:0] {
    SEEK,
    RUN,
    FLUSH
  } svo_state_t;

  // Derived raster timing; sync windows are [start, end).
  typedef struct packed {
    int unsigned h_total;
    int unsigned h_sync_start;
    int unsigned h_sync_end;
    int unsigned v_total;
    int unsigned v_sync_start;
    int unsigned v_sync_end;
  } svo_timing_t;

  function automatic svo_timing_t svo_timing(
    input int unsigned hp, input int unsigned hfp, input int unsigned hs, input int unsigned hbp,
    input int unsigned vp, input int unsigned vfp, input int unsigned vs, input int unsigned vbp
  );
    svo_timing_t t;
    t.h_total      = hp + hfp + hs + hbp;
    t.h_sync_start = hp + hfp;
    t.h_sync_end   = hp + hfp + hs;
    t.v_total      = vp + vfp + vs + vbp;
    t.v_sync_start = vp + vfp;
    t.v_sync_end   = vp + vfp + vs;
    return t;
  endfunction

endpackage

// File: rtl/svo_raster_counter.sv
// Raster position counter with sync/blank/frame-start decode of the current position.
module svo_raster_counter
  import svo_pkg::*;
#(
  parameter int unsigned HOR_PIXELS      = 640,
  parameter int unsigned HOR_FRONT_PORCH = 16,
  parameter int unsigned HOR_SYNC        = 96,
  parameter int unsigned HOR_BACK_PORCH  = 48,
  parameter int unsigned VER_PIXELS      = 480,
  parameter int unsigned VER_FRONT_PORCH = 10,
  parameter int unsigned VER_SYNC        = 2,
  parameter int unsigned VER_BACK_PORCH  = 33,
  parameter bit          HSYNC_POL       = 1'b0,
  parameter bit          VSYNC_POL       = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic hsync_c,
  output logic vsync_c,
  output logic blank_c,
  output logic fstart_c,
  output logic last_c
);

  localparam svo_timing_t TIM = svo_timing(HOR_PIXELS, HOR_FRONT_PORCH, HOR_SYNC, HOR_BACK_PORCH,
                                           VER_PIXELS, VER_FRONT_PORCH, VER_SYNC, VER_BACK_PORCH);
  localparam int unsigned HW = $clog2(TIM.h_total);
  localparam int unsigned VW = $clog2(TIM.v_total);

  localparam logic [HW-1:0] H_LAST = HW'(TIM.h_total - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(HOR_PIXELS);
  localparam logic [HW-1:0] H_SS   = HW'(TIM.h_sync_start);
  localparam logic [HW-1:0] H_SE   = HW'(TIM.h_sync_end);
  localparam logic [VW-1:0] V_LAST = VW'(TIM.v_total - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(VER_PIXELS);
  localparam logic [VW-1:0] V_SS   = VW'(TIM.v_sync_start);
  localparam logic [VW-1:0] V_SE   = VW'(TIM.v_sync_end);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  // Position advances one beat per enable; clear forces the frame origin.
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (en) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
      end else begin
        hcnt <= hcnt + HW'(1);
      end
    end
  end

  // Flag decode for the beat at the current position.
  always_comb begin
    blank_c  = !((hcnt < H_ACT) && (vcnt < V_ACT));
    hsync_c  = ((hcnt >= H_SS) && (hcnt < H_SE)) ? HSYNC_POL : !HSYNC_POL;
    vsync_c  = ((vcnt >= V_SS) && (vcnt < V_SE)) ? VSYNC_POL : !VSYNC_POL;
    fstart_c = (hcnt == '0) && (vcnt == '0);
    last_c   = (hcnt == H_LAST) && (vcnt == V_LAST);
  end

endmodule

// File: rtl/svo_sync_inserter.sv
// Expands an active-pixel stream into a full raster with generated blanking and sync flags.
module svo_sync_inserter
  import svo_pkg::*;
#(
  parameter int unsigned HOR_PIXELS      = 640,
  parameter int unsigned HOR_FRONT_PORCH = 16,
  parameter int unsigned HOR_SYNC        = 96,
  parameter int unsigned HOR_BACK_PORCH  = 48,
  parameter int unsigned VER_PIXELS      = 480,
  parameter int unsigned VER_FRONT_PORCH = 10,
  parameter int unsigned VER_SYNC        = 2,
  parameter int unsigned VER_BACK_PORCH  = 33,
  parameter int unsigned BITS_PER_PIXEL  = 24,
  parameter bit          HSYNC_POL       = 1'b0,
  parameter bit          VSYNC_POL       = 1'b0
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      in_axis_tvalid,
  output logic                      in_axis_tready,
  input  logic [BITS_PER_PIXEL-1:0] in_axis_tdata,
  input  logic [0:0]                in_axis_tuser,
  output logic                      out_axis_tvalid,
  input  logic                      out_axis_tready,
  output logic [BITS_PER_PIXEL-1:0] out_axis_tdata,
  output logic [TUSER_W-1:0]        out_axis_tuser,
  output logic                      resync
);

  svo_state_t                state, state_n;
  logic                      advance_c, in_ready_c, cnt_en_c, seek_c;
  logic                      tvalid_n, resync_n;
  logic [BITS_PER_PIXEL-1:0] tdata_n;
  logic [TUSER_W-1:0]        tuser_n;
  logic                      hsync_c, vsync_c, blank_c, fstart_c, last_c;

  svo_raster_counter #(
    .HOR_PIXELS     (HOR_PIXELS),
    .HOR_FRONT_PORCH(HOR_FRONT_PORCH),
    .HOR_SYNC       (HOR_SYNC),
    .HOR_BACK_PORCH (HOR_BACK_PORCH),
    .VER_PIXELS     (VER_PIXELS),
    .VER_FRONT_PORCH(VER_FRONT_PORCH),
    .VER_SYNC       (VER_SYNC),
    .VER_BACK_PORCH (VER_BACK_PORCH),
    .HSYNC_POL      (HSYNC_POL),
    .VSYNC_POL      (VSYNC_POL)
  ) u_raster (
    .clk     (clk),
    .resetn  (resetn),
    .en      (cnt_en_c),
    .clr     (seek_c),
    .hsync_c (hsync_c),
    .vsync_c (vsync_c),
    .blank_c (blank_c),
    .fstart_c(fstart_c),
    .last_c  (last_c)
  );

  // Counter sits at the frame origin while hunting for SOF.
  assign seek_c = (state == SEEK);

  // Input is never accepted while reset is held, whatever the stale state says.
  assign in_axis_tready = resetn && in_ready_c;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= SEEK;
    end else begin
      state <= state_n;
    end
  end

  // Next state, input ready and next output beat for the current raster position.
  always_comb begin
    advance_c  = !out_axis_tvalid || out_axis_tready;
    state_n    = state;
    in_ready_c = 1'b0;
    cnt_en_c   = 1'b0;
    tvalid_n   = 1'b0;
    resync_n   = 1'b0;
    tdata_n    = '0;
    tuser_n    = '0;
    tuser_n[TUSER_HSYNC]  = hsync_c;
    tuser_n[TUSER_VSYNC]  = vsync_c;
    tuser_n[TUSER_BLANK]  = blank_c;
    tuser_n[TUSER_FSTART] = fstart_c;
    case (state)
      SEEK: begin
        // Drop everything up to SOF; leave SOF at the head for RUN to take.
        in_ready_c = !in_axis_tuser[0];
        if (in_axis_tvalid && in_axis_tuser[0]) begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (!blank_c) begin
          in_ready_c = advance_c;
          if (in_axis_tvalid && advance_c) begin
            tvalid_n = 1'b1;
            cnt_en_c = 1'b1;
            tdata_n  = in_axis_tdata;
            // SOF must coincide with the origin; otherwise blank out the frame.
            if (in_axis_tuser[0] != fstart_c) begin
              resync_n = 1'b1;
              state_n  = FLUSH;
              if (fstart_c) begin
                tdata_n = '0;
              end
            end
          end
        end else if (advance_c) begin
          tvalid_n = 1'b1;
          cnt_en_c = 1'b1;
        end
      end
      FLUSH: begin
        if (advance_c) begin
          tvalid_n = 1'b1;
          cnt_en_c = 1'b1;
          if (last_c) begin
            state_n = SEEK;
          end
        end
      end
      default: state_n = SEEK;
    endcase
  end

  // Output beat register; holds while the downstream stalls a valid beat.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_axis_tvalid <= 1'b0;
      out_axis_tdata  <= '0;
      out_axis_tuser  <= '0;
      resync          <= 1'b0;
    end else begin
      resync <= resync_n;
      if (advance_c) begin
        out_axis_tvalid <= tvalid_n;
        out_axis_tdata  <= tdata_n;
        out_axis_tuser  <= tuser_n;
      end
    end
  end

endmodule

// File: tb/tb_svo_sync_inserter.sv
// Scoreboard bench for svo_sync_inserter on a tiny 8x6 raster.
module tb_svo_sync_inserter;

  localparam int unsigned HT  = 8;
  localparam int unsigned VT  = 6;
  localparam int unsigned FRM = HT * VT;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_axis_tvalid = 1'b0;
  logic        in_axis_tready;
  logic [23:0] in_axis_tdata = '0;
  logic [0:0]  in_axis_tuser = '0;
  logic        out_axis_tvalid;
  logic        out_axis_tready = 1'b1;
  logic [23:0] out_axis_tdata;
  logic [3:0]  out_axis_tuser;
  logic        resync;

  svo_sync_inserter #(
    .HOR_PIXELS(4), .HOR_FRONT_PORCH(1), .HOR_SYNC(2), .HOR_BACK_PORCH(1),
    .VER_PIXELS(3), .VER_FRONT_PORCH(1), .VER_SYNC(1), .VER_BACK_PORCH(1),
    .BITS_PER_PIXEL(24), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .in_axis_tvalid (in_axis_tvalid),
    .in_axis_tready (in_axis_tready),
    .in_axis_tdata  (in_axis_tdata),
    .in_axis_tuser  (in_axis_tuser),
    .out_axis_tvalid(out_axis_tvalid),
    .out_axis_tready(out_axis_tready),
    .out_axis_tdata (out_axis_tdata),
    .out_axis_tuser (out_axis_tuser),
    .resync         (resync)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int beats  = 0;
  int resync_seen = 0;
  int exp_resync  = 0;
  bit rdy_rand = 1'b0;
  bit gap_en   = 1'b0;

  logic [23:0] exp_data_q[$];
  logic [3:0]  exp_user_q[$];

  // Reference model state: hunting for SOF, and next raster index 0..FRM-1.
  bit m_seek = 1'b1;
  int m_pos  = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic bit is_blank(input int p);
    return !(((p % HT) < 4) && ((p / HT) < 3));
  endfunction

  // Expected tuser for raster index p: {fstart, blank, vsync_n, hsync_n}.
  function automatic logic [3:0] flags(input int p);
    int h = p % HT;
    int v = p / HT;
    return {p == 0, is_blank(p), !(v == 4), !(h == 5 || h == 6)};
  endfunction

  function automatic void push(input logic [23:0] d, input int p);
    exp_data_q.push_back(d);
    exp_user_q.push_back(flags(p));
  endfunction

  // Feed one accepted input beat to the model; blanking after it is emitted eagerly.
  function automatic void model_in(input logic [23:0] d, input bit sof);
    if (m_seek) begin
      if (!sof) return;
      m_seek = 1'b0;
      m_pos  = 0;
    end
    if (sof != (m_pos == 0)) begin
      exp_resync++;
      push((m_pos == 0) ? 24'd0 : d, m_pos);
      for (int p = m_pos + 1; p < FRM; p++) push(24'd0, p);
      m_pos  = 0;
      m_seek = 1'b1;
      return;
    end
    push(d, m_pos);
    m_pos = (m_pos + 1) % FRM;
    while (is_blank(m_pos)) begin
      push(24'd0, m_pos);
      m_pos = (m_pos + 1) % FRM;
    end
  endfunction

  task automatic send(input logic [23:0] d, input bit sof);
    int n = 0;
    bit done = 1'b0;
    model_in(d, sof);
    in_axis_tvalid = 1'b1;
    in_axis_tdata  = d;
    in_axis_tuser  = sof;
    while (!done) begin
      @(negedge clk);
      if (in_axis_tready) begin
        done = 1'b1;
      end else if (++n > 3000) begin
        checks++;
        fails++;
        $display("FAIL input_accept_timeout: got no handshake in 3000 cycles, required one");
        done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    in_axis_tvalid = 1'b0;
    if (gap_en) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pixels(input int n);
    for (int i = 0; i < n; i++) send(24'($urandom), i == 0);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_data_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(exp_data_q.size()), 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int b0;
    logic        stall_prev = 1'b0;
    logic        resync_prev = 1'b0;
    logic [23:0] prev_data = '0;
    logic [3:0]  prev_user = '0;

    fork
      // Downstream ready, changed just after each active edge.
      forever begin
        @(posedge clk);
        #1;
        out_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      // Monitor: pops the scoreboard on each output handshake and checks stall stability.
      forever begin
        @(negedge clk);
        if (!resetn) begin
          stall_prev  = 1'b0;
          resync_prev = 1'b0;
        end else begin
          if (stall_prev) begin
            chk("stall_tvalid", 32'(out_axis_tvalid), 32'd1);
            chk("stall_tdata", 32'(out_axis_tdata), 32'(prev_data));
            chk("stall_tuser", 32'(out_axis_tuser), 32'(prev_user));
          end
          if (out_axis_tvalid && out_axis_tready) begin
            if (exp_data_q.size() == 0) begin
              checks++;
              fails++;
              $display("FAIL unexpected_beat: got tdata %0h tuser %0h, required no beat",
                       out_axis_tdata, out_axis_tuser);
            end else begin
              chk("beat_tdata", 32'(out_axis_tdata), 32'(exp_data_q.pop_front()));
              chk("beat_tuser", 32'(out_axis_tuser), 32'(exp_user_q.pop_front()));
            end
            beats++;
          end
          stall_prev = out_axis_tvalid && !out_axis_tready;
          prev_data  = out_axis_tdata;
          prev_user  = out_axis_tuser;
          if (resync) begin
            resync_seen++;
            chk("resync_one_cycle", 32'(resync_prev), 32'd0);
          end
          resync_prev = resync;
        end
      end
    join_none

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 32'(out_axis_tvalid), 32'd0);
    chk("rst_tdata", 32'(out_axis_tdata), 32'd0);
    chk("rst_tuser", 32'(out_axis_tuser), 32'd0);
    chk("rst_resync", 32'(resync), 32'd0);
    chk("rst_in_tready", 32'(in_axis_tready), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Garbage before SOF, then one clean frame with full downstream ready.
    for (int i = 0; i < 3; i++) send(24'($urandom), 1'b0);
    send_pixels(12);
    wait_drain("frame1_drain");
    chk("frame1_beats", 32'(beats), 32'(FRM));
    chk("frame1_resync", 32'(resync_seen), 32'(exp_resync));

    // Three frames under random backpressure and input gaps.
    rdy_rand = 1'b1;
    gap_en   = 1'b1;
    b0 = beats;
    for (int f = 0; f < 3; f++) send_pixels(12);
    wait_drain("random_drain");
    chk("random_raster_beats", 32'(beats - b0), 32'(3 * FRM));

    // SOF arrives on the sixth pixel of a frame, then a clean frame follows.
    send_pixels(5);
    send_pixels(12);
    send_pixels(12);
    wait_drain("misalign_drain");
    chk("misalign_resync", 32'(resync_seen), 32'(exp_resync));

    // Stop mid-line at (2,1), pulse reset for one cycle, then a clean frame.
    rdy_rand = 1'b0;
    gap_en   = 1'b0;
    send_pixels(6);
    wait_drain("partial_drain");
    @(posedge clk);
    #1;
    resetn         = 1'b0;
    in_axis_tvalid = 1'b1;
    in_axis_tdata  = 24'h123456;
    in_axis_tuser  = 1'b1;
    @(negedge clk);
    chk("midrst_in_tready_low", 32'(in_axis_tready), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("midrst_tvalid", 32'(out_axis_tvalid), 32'd0);
    chk("midrst_in_tready", 32'(in_axis_tready), 32'd0);
    chk("midrst_queue_empty", 32'(exp_data_q.size()), 32'd0);
    m_seek = 1'b1;
    m_pos  = 0;
    b0 = beats;
    send_pixels(12);
    wait_drain("post_reset_drain");
    chk("post_reset_beats", 32'(beats - b0), 32'(FRM));
    chk("final_resync", 32'(resync_seen), 32'(exp_resync));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
